// File: rtl/accumulator_buffer.sv
// Row store behind the column-alignment stage: overwrites or saturating-accumulates
// aligned (col0,col1) pairs per row, then drains all rows over valid/ready.
module accumulator_buffer #(
  parameter int DEPTH = 4,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_col0,
  input  logic [IN_W-1:0]  in_col1,
  input  logic             acc_en,
  input  logic             drain_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_col0,
  output logic [ACC_W-1:0] out_col1,
  output logic             busy,
  output logic             drain_done,
  output logic             ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic signed [ACC_W-1:0] row0 [DEPTH];
  logic signed [ACC_W-1:0] row1 [DEPTH];

  function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] v);
    return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  // One guard bit catches overflow; clamp instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? SAT_MIN : SAT_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign out_col0 = row0[rd_ptr];
  assign out_col1 = row1[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
      ovf_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        row0[i] <= '0;
        row1[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      case (state)
        FILL: begin
          // A write coinciding with drain_req lands before the first beat.
          if (in_valid) begin
            row0[wr_ptr] <= acc_en ? sat_add(row0[wr_ptr], sext(in_col0)) : sext(in_col0);
            row1[wr_ptr] <= acc_en ? sat_add(row1[wr_ptr], sext(in_col1)) : sext(in_col1);
            wr_ptr       <= wr_ptr + PTR_W'(1);
          end
          if (drain_req) begin
            state     <= DRAIN;
            rd_ptr    <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_valid)
            ovf_err <= 1'b1;
          if (out_ready) begin
            if (rd_ptr == LAST_ROW) begin
              state      <= FILL;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              drain_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_buffer.sv
// Bench for accumulator_buffer: directed scenarios plus randomized passes checked
// against a transaction-level row model with saturating integer arithmetic.
module tb_accumulator_buffer;

  localparam int DEPTH = 4;
  localparam int IN_W  = 16;
  localparam int ACC_W = 17;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    clear = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_col0 = '0;
  logic signed [IN_W-1:0]  in_col1 = '0;
  logic                    acc_en = 1'b0;
  logic                    drain_req = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] out_col0;
  logic signed [ACC_W-1:0] out_col1;
  logic                    busy;
  logic                    drain_done;
  logic                    ovf_err;

  accumulator_buffer #(.DEPTH(DEPTH), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_col0(in_col0), .in_col1(in_col1), .acc_en(acc_en),
    .drain_req(drain_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_col0(out_col0), .out_col1(out_col1), .busy(busy),
    .drain_done(drain_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  longint m0 [DEPTH];
  longint m1 [DEPTH];
  int     mwr;
  bit     movf;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = 0;
      m1[i] = 0;
    end
    mwr  = 0;
    movf = 1'b0;
  endtask

  task automatic model_write(input logic signed [IN_W-1:0] c0, input logic signed [IN_W-1:0] c1,
                             input bit acc);
    m0[mwr] = acc ? clamp(m0[mwr] + longint'(c0)) : longint'(c0);
    m1[mwr] = acc ? clamp(m1[mwr] + longint'(c1)) : longint'(c1);
    mwr = (mwr + 1) % DEPTH;
  endtask

  task automatic write_pair(input logic signed [IN_W-1:0] c0, input logic signed [IN_W-1:0] c1,
                            input bit acc);
    in_valid = 1'b1;
    in_col0  = c0;
    in_col1  = c1;
    acc_en   = acc;
    tick();
    in_valid = 1'b0;
    model_write(c0, c1, acc);
  endtask

  task automatic write_pass(input logic signed [IN_W-1:0] c0, input logic signed [IN_W-1:0] c1,
                            input bit acc);
    for (int i = 0; i < DEPTH; i++) write_pair(c0, c1, acc);
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready plus stray drain_req
  task automatic run_drain(input int rmode, input bit inject, input bit sim,
                           input logic signed [IN_W-1:0] s0, input logic signed [IN_W-1:0] s1);
    longint e0 [DEPTH];
    longint e1 [DEPTH];
    int beat;
    int cyc;
    bit r;
    if (sim) begin
      in_valid = 1'b1;
      in_col0  = s0;
      in_col1  = s1;
      acc_en   = 1'b0;
    end
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    in_valid  = 1'b0;
    if (sim) model_write(s0, s1, 1'b0);
    e0 = m0;
    e1 = m1;
    chk("busy_start", busy, 1);
    beat = 0;
    cyc  = 0;
    while (beat < DEPTH && cyc < 200) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      chk("out_valid_drain", out_valid, 1);
      chk("busy_drain", busy, 1);
      chk("done_low_drain", drain_done, 0);
      chk("beat_col0", out_col0, e0[beat]);
      chk("beat_col1", out_col1, e1[beat]);
      if (inject && cyc == 1) begin
        in_valid = 1'b1;
        in_col0  = 16'($urandom);
        in_col1  = 16'($urandom);
        movf     = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      drain_req = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cyc++;
      if (r) beat++;
    end
    in_valid  = 1'b0;
    drain_req = 1'b0;
    out_ready = 1'b0;
    chk("drain_beats", beat, DEPTH);
    chk("done_pulse", drain_done, 1);
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("ovf_err", ovf_err, movf);
    mwr = 0;
    tick();
    chk("done_one_cycle", drain_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_col0", out_col0, 0);
    chk("rst_col1", out_col1, 0);

    // Overwrite
    write_pair(16'sd1, 16'sd2, 1'b0);
    write_pair(16'sd3, 16'sd4, 1'b0);
    write_pair(-16'sd5, 16'sd6, 1'b0);
    write_pair(16'sd7, -16'sd8, 1'b0);
    run_drain(0, 1'b0, 1'b0, '0, '0);

    // Accumulate over two passes
    write_pass(16'sd10, 16'sd20, 1'b0);
    write_pass(-16'sd3, 16'sd5, 1'b1);
    run_drain(0, 1'b0, 1'b0, '0, '0);

    // Saturation at both rails (ACC_W = 17)
    write_pass(16'sh7FFF, -16'sh8000, 1'b0);
    write_pass(16'sh7FFF, -16'sh8000, 1'b1);
    write_pass(16'sd1, -16'sd1, 1'b1);
    write_pass(16'sh7FFF, -16'sh8000, 1'b1);
    chk("model_sat_max", m0[0], 65535);
    run_drain(0, 1'b0, 1'b0, '0, '0);

    // Backpressure with dropped input
    write_pair(16'sd11, -16'sd12, 1'b0);
    write_pair(16'sd13, 16'sd14, 1'b0);
    write_pair(-16'sd15, 16'sd16, 1'b0);
    write_pair(16'sd17, 16'sd18, 1'b0);
    run_drain(1, 1'b1, 1'b0, '0, '0);

    // Write coinciding with drain_req at wr_ptr=3
    write_pair(16'sd1, 16'sd1, 1'b0);
    write_pair(16'sd2, 16'sd2, 1'b0);
    write_pair(16'sd3, 16'sd3, 1'b0);
    run_drain(0, 1'b0, 1'b1, 16'sd9, 16'sd9);

    // clear in the middle of a drain
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("pre_clear_ovf", ovf_err, 1);
    chk("pre_clear_busy", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    chk("clear_out_valid", out_valid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_ovf", ovf_err, 0);
    chk("clear_done", drain_done, 0);
    run_drain(0, 1'b0, 1'b0, '0, '0);

    // Randomized passes
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(0, 9);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        write_pair(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      run_drain($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        chk("rand_clear_ovf", ovf_err, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
